// File: rtl/nios_system_cpu_oci_dct_pkg.sv
// Shared sizes, FSM encoding and the atom-placement helper for the OCI data-trace packer.
package nios_system_cpu_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int ATOMS  = 15;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = ATOM_W * ATOMS;
  localparam int WORD_W = BUF_W + CNT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_DRAIN = 2'd2,
    S_END   = 2'd3
  } state_e;

  // Writes one atom into the given slot; a slot index of ATOMS or more leaves the buffer unchanged.
  function automatic logic [BUF_W-1:0] place_atom(input logic [BUF_W-1:0]  buf_in,
                                                  input logic [CNT_W-1:0]  slot,
                                                  input logic [ATOM_W-1:0] atom);
    logic [BUF_W-1:0] r;
    r = buf_in;
    for (int k = 0; k < ATOMS; k++) begin
      if (slot == CNT_W'(k)) r[k*ATOM_W +: ATOM_W] = atom;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_system_cpu_oci_dct_outreg.sv
// One-deep valid/ready holding register for packed trace words; data reads as zero while empty.
module nios_system_cpu_oci_dct_outreg
  import nios_system_cpu_oci_dct_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !full_q || out_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (full_q && out_ready) begin
      full_d = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/nios_system_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit words and drives the test-ending handshake.
// Optional feature macro OCI_DCT_DROP_CNT_EN: never back-pressure, drop and count atoms instead.
module nios_system_cpu_oci_dct_packer
  import nios_system_cpu_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_enable,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              flush,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
`ifdef OCI_DCT_DROP_CNT_EN
  output logic [15:0]       dropped_atoms,
`endif
  output logic              test_ending,
  output logic              test_has_ended
);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   acc_buf_q, acc_buf_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;
  logic               out_free;
  logic               acc_full, stall, in_pack, acc_wr, xfer;
  logic [WORD_W-1:0]  word_out;

  assign in_pack  = (state_q == S_PACK);
  assign acc_full = (acc_cnt_q == CNT_W'(ATOMS));
  assign stall    = acc_full && word_valid && !word_ready;
  assign acc_wr   = atom_valid && in_pack && !stall;
  assign xfer     = out_free && (acc_full || (state_q == S_DRAIN && acc_cnt_q != '0));

`ifdef OCI_DCT_DROP_CNT_EN
  assign atom_ready = in_pack;
`else
  assign atom_ready = in_pack && !stall;
`endif

  nios_system_cpu_oci_dct_outreg #(.W(WORD_W)) u_outreg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (xfer),
    .in_data   ({acc_cnt_q, acc_buf_q}),
    .in_ready  (out_free),
    .out_valid (word_valid),
    .out_data  (word_out),
    .out_ready (word_ready)
  );

  assign {dct_count, dct_buffer} = word_out;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

  // A transfer empties the accumulator first, so a same-cycle atom lands in slot 0.
  always_comb begin
    acc_buf_d = acc_buf_q;
    acc_cnt_d = acc_cnt_q;
    if (xfer) begin
      acc_buf_d = '0;
      acc_cnt_d = '0;
    end
    if (acc_wr) begin
      acc_buf_d = place_atom(acc_buf_d, acc_cnt_d, atom_data);
      acc_cnt_d = acc_cnt_d + CNT_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;
    case (state_q)
      S_IDLE: if (trace_enable) begin
        state_d          = S_PACK;
        test_has_ended_d = 1'b0;
      end
      S_PACK: begin
        if (flush) begin
          state_d       = S_DRAIN;
          test_ending_d = 1'b1;
        end else if (!trace_enable) begin
          state_d = S_IDLE;
        end
      end
      // Final word has gone once the accumulator is empty and the out reg is empty or handing off.
      S_DRAIN: if (acc_cnt_q == '0 && out_free) begin
        state_d          = S_END;
        test_ending_d    = 1'b0;
        test_has_ended_d = 1'b1;
      end
      S_END: if (!trace_enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef OCI_DCT_DROP_CNT_EN
  logic [15:0] dropped_q, dropped_d;

  assign dropped_atoms = dropped_q;

  always_comb begin
    dropped_d = dropped_q;
    if (state_q == S_IDLE && trace_enable) dropped_d = '0;
    else if (atom_valid && in_pack && stall && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped_q <= '0;
    else       dropped_q <= dropped_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      acc_buf_q        <= '0;
      acc_cnt_q        <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_buf_q        <= acc_buf_d;
      acc_cnt_q        <= acc_cnt_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_oci_dct_packer.sv
// Directed bench for the OCI data-trace packer: vector table plus hand-written multi-cycle sequences.
module tb_nios_system_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        word_valid;
  logic        word_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
`ifdef OCI_DCT_DROP_CNT_EN
  logic [15:0] dropped_atoms;
`endif

  nios_system_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .trace_enable   (trace_enable),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
`ifdef OCI_DCT_DROP_CNT_EN
    .dropped_atoms  (dropped_atoms),
`endif
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        te, av;
    logic [1:0]  ad;
    logic        fl, wr;
    logic        ar, wv;
    logic [29:0] dbuf;
    logic [3:0]  cnt;
    logic        ting, ted;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          sent;
  logic        s_ar;
  logic [33:0] got_q[$];
  logic [1:0]  atoms_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample just after the inputs settle, then advance to 1 time unit past the next edge.
  task automatic tick();
    #1;
    s_ar = atom_ready;
    if (word_valid && word_ready) got_q.push_back({dct_count, dct_buffer});
    if (atom_valid && atom_ready) begin
      sent++;
      atoms_q.push_back(atom_data);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] mkword(input int base, input int n);
    logic [29:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[2*k +: 2] = atoms_q[base+k];
    return {4'(n), b};
  endfunction

  function automatic vec_t mk(input logic te, av, input logic [1:0] ad, input logic fl, wr,
                              input logic ar, wv, input logic [29:0] dbuf, input logic [3:0] cnt,
                              input logic ting, ted);
    vec_t v;
    v.te = te; v.av = av; v.ad = ad; v.fl = fl; v.wr = wr;
    v.ar = ar; v.wv = wv; v.dbuf = dbuf; v.cnt = cnt; v.ting = ting; v.ted = ted;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic        all_ready;
    logic [29:0] held;

    //           te av ad fl wr | ar wv dbuf        cnt ting ted
    tbl[0]  = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   0);
    tbl[1]  = mk(1, 1, 3, 0, 1,   1, 0, 30'h0,      0,  0,   0);
    tbl[2]  = mk(1, 1, 2, 0, 1,   1, 0, 30'h0,      0,  0,   0);
    tbl[3]  = mk(1, 1, 1, 0, 1,   1, 0, 30'h0,      0,  0,   0);
    tbl[4]  = mk(1, 1, 0, 1, 1,   1, 0, 30'h0,      0,  0,   0);
    tbl[5]  = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  1,   0);
    tbl[6]  = mk(1, 0, 0, 0, 0,   0, 1, 30'h1B,     4,  1,   0);
    tbl[7]  = mk(1, 0, 0, 0, 1,   0, 1, 30'h1B,     4,  1,   0);
    tbl[8]  = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   1);
    tbl[9]  = mk(0, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   1);
    tbl[10] = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   1);
    tbl[11] = mk(1, 0, 0, 1, 1,   1, 0, 30'h0,      0,  0,   0);
    tbl[12] = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  1,   0);
    tbl[13] = mk(1, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   1);
    tbl[14] = mk(0, 0, 0, 0, 1,   0, 0, 30'h0,      0,  0,   1);

    reset = 1'b1; trace_enable = 1'b0; atom_valid = 1'b0; atom_data = 2'd0;
    flush = 1'b0; word_ready = 1'b0;
    #3;
    chk("reset_atom_ready", 64'(atom_ready), 64'd0);
    chk("reset_word_valid", 64'(word_valid), 64'd0);
    chk("reset_dct_buffer", 64'(dct_buffer), 64'd0);
    chk("reset_dct_count", 64'(dct_count), 64'd0);
    chk("reset_test_ending", 64'(test_ending), 64'd0);
    chk("reset_test_has_ended", 64'(test_has_ended), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Partial word via flush with stall, then flush of an empty accumulator.
    for (int i = 0; i < 15; i++) begin
      trace_enable = tbl[i].te; atom_valid = tbl[i].av; atom_data = tbl[i].ad;
      flush = tbl[i].fl; word_ready = tbl[i].wr;
      #1;
      chk($sformatf("v%0d_atom_ready", i), 64'(atom_ready), 64'(tbl[i].ar));
      chk($sformatf("v%0d_word_valid", i), 64'(word_valid), 64'(tbl[i].wv));
      chk($sformatf("v%0d_dct_buffer", i), 64'(dct_buffer), 64'(tbl[i].dbuf));
      chk($sformatf("v%0d_dct_count", i), 64'(dct_count), 64'(tbl[i].cnt));
      chk($sformatf("v%0d_test_ending", i), 64'(test_ending), 64'(tbl[i].ting));
      chk($sformatf("v%0d_test_has_ended", i), 64'(test_has_ended), 64'(tbl[i].ted));
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // Fifteen back-to-back atoms with free downstream produce exactly one full word.
    got_q.delete(); atoms_q.delete(); sent = 0;
    trace_enable = 1'b1; word_ready = 1'b1; atom_valid = 1'b0;
    tick();
    all_ready = 1'b1;
    atom_valid = 1'b1; atom_data = 2'b01;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!s_ar) all_ready = 1'b0;
    end
    atom_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t1_ready_throughout", 64'(all_ready), 64'd1);
    chk("t1_word_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) chk("t1_word", 64'(got_q[0]), 64'({4'd15, 30'h15555555}));

`ifndef OCI_DCT_DROP_CNT_EN
    // Thirty-one atoms against a blocked downstream: stall after thirty, then drain three words.
    got_q.delete(); atoms_q.delete(); sent = 0;
    word_ready = 1'b0;
    for (int c = 0; c < 100 && sent < 30; c++) begin
      atom_valid = 1'b1; atom_data = 2'((sent * 3 + 1) % 4);
      tick();
    end
    chk("t2_sent_before_stall", 64'(sent), 64'd30);
    tick();
    chk("t2_stall_ready", 64'(s_ar), 64'd0);
    chk("t2_stall_sent", 64'(sent), 64'd30);
    held = dct_buffer;
    chk("t2_stall_word", 64'({dct_count, dct_buffer}), 64'(mkword(0, 15)));
    for (int i = 0; i < 3; i++) tick();
    chk("t2_stable_valid", 64'(word_valid), 64'd1);
    chk("t2_stable_buffer", 64'(dct_buffer), 64'(held));
    word_ready = 1'b1;
    for (int c = 0; c < 10 && sent < 31; c++) tick();
    chk("t2_sent_total", 64'(sent), 64'd31);
    atom_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 20 && !test_has_ended; c++) tick();
    chk("t2_has_ended", 64'(test_has_ended), 64'd1);
    chk("t2_word_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("t2_word0", 64'(got_q[0]), 64'(mkword(0, 15)));
      chk("t2_word1", 64'(got_q[1]), 64'(mkword(15, 15)));
      chk("t2_word2", 64'(got_q[2]), 64'(mkword(30, 1)));
    end
    trace_enable = 1'b0;
    tick();
`endif

    // Asynchronous reset with seven atoms pending discards them.
    trace_enable = 1'b1; word_ready = 1'b1;
    tick();
    atom_valid = 1'b1; atom_data = 2'b11;
    for (int i = 0; i < 7; i++) tick();
    atom_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_atom_ready", 64'(atom_ready), 64'd0);
    chk("t5_rst_word_valid", 64'(word_valid), 64'd0);
    chk("t5_rst_dct_buffer", 64'(dct_buffer), 64'd0);
    chk("t5_rst_dct_count", 64'(dct_count), 64'd0);
    chk("t5_rst_test_ending", 64'(test_ending), 64'd0);
    chk("t5_rst_test_has_ended", 64'(test_has_ended), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete(); atoms_q.delete(); sent = 0;
    tick();
    atom_valid = 1'b1; atom_data = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    atom_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_word_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) chk("t5_word", 64'(got_q[0]), 64'({4'd15, 30'h15555555}));

`ifdef OCI_DCT_DROP_CNT_EN
    // Blocked downstream: fill the out reg, then twenty atoms of which five are dropped.
    word_ready = 1'b0; all_ready = 1'b1;
    atom_valid = 1'b1; atom_data = 2'b10;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (!s_ar) all_ready = 1'b0;
    end
    atom_valid = 1'b0;
    tick();
    chk("t6_ready_constant", 64'(all_ready), 64'd1);
    chk("t6_dropped", 64'(dropped_atoms), 64'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
